// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: host master that loads A/B into the 2x2 matmul controller, waits for done and reads C back
module tpu_host_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SETTLE_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] A_flat,
    input  logic [31:0] B_flat,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] C_flat,
    output logic        err,
    output logic        ctrl_rst,
    output logic        load_en,
    output logic        load_sel_ab,
    output logic [1:0]  load_index,
    output logic [7:0]  in_data,
    output logic        output_en,
    output logic [1:0]  output_sel,
    input  logic [7:0]  out_data,
    input  logic        done
);
    typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, SETTLE, READ, RESP} state_t;
    localparam int MAXC = TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
    state_t state, state_n;
    logic [2:0]    beat, beat_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   a_q, b_q;
    logic [63:0]   ab;
    logic          timeout;
    assign job_ready = state == IDLE;
    assign ab = {b_q, a_q};
    // next state plus the shared beat counter (load/read) and wait/settle counter
    always_comb begin
        state_n = state;
        beat_n  = beat;
        cnt_n   = cnt;
        timeout = 1'b0;
        case (state)
            IDLE: state_n = job_valid ? CLR : IDLE;
            CLR: begin
                state_n = LOAD;
                beat_n  = 3'd0;
            end
            LOAD: begin
                state_n = beat == 3'd7 ? WAIT : LOAD;
                beat_n  = beat + 3'd1;
                cnt_n   = '0;
            end
            WAIT: begin
                timeout = !done && cnt == T_LAST;
                state_n = done ? (SETTLE_CYCLES == 0 ? READ : SETTLE) : timeout ? RESP : WAIT;
                cnt_n   = done ? '0 : cnt + CW'(1);
                beat_n  = 3'd0;
            end
            SETTLE: begin
                state_n = cnt == S_LAST ? READ : SETTLE;
                cnt_n   = cnt + CW'(1);
            end
            READ: begin
                state_n = beat == 3'd3 ? RESP : READ;
                beat_n  = beat + 3'd1;
            end
            RESP: state_n = res_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // state, job capture, and outputs registered from the next-state view so they line up with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= 3'd0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            C_flat      <= '0;
            err         <= 1'b0;
            res_valid   <= 1'b0;
            ctrl_rst    <= 1'b0;
            load_en     <= 1'b0;
            load_sel_ab <= 1'b0;
            load_index  <= 2'd0;
            in_data     <= 8'd0;
            output_en   <= 1'b0;
            output_sel  <= 2'd0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            cnt         <= cnt_n;
            if (job_valid && job_ready) begin
                a_q <= A_flat;
                b_q <= B_flat;
            end
            ctrl_rst    <= state_n == CLR;
            load_en     <= state_n == LOAD;
            load_sel_ab <= state_n == LOAD && beat_n[2];
            load_index  <= state_n == LOAD ? beat_n[1:0] : 2'd0;
            in_data     <= state_n == LOAD ? ab[{beat_n, 3'b000} +: 8] : 8'd0;
            output_en   <= state_n == READ;
            output_sel  <= state_n == READ ? beat_n[1:0] : 2'd0;
            res_valid   <= state_n == RESP;
            if (output_en) C_flat[{output_sel, 3'b000} +: 8] <= out_data;
            else if (timeout) C_flat <= '0;
            err <= timeout | (err & !(state == RESP && res_ready));
        end
    end
endmodule

// File: tb/tb_tpu_host_sequencer.sv
// tb_tpu_host_sequencer: table-driven and random jobs against a controller/mmu model
module tb_tpu_host_sequencer;
    localparam int TO = 64;
    localparam int SC = 1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] A_flat = '0;
    logic [31:0] B_flat = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] C_flat;
    logic        err;
    logic        ctrl_rst;
    logic        load_en;
    logic        load_sel_ab;
    logic [1:0]  load_index;
    logic [7:0]  in_data;
    logic        output_en;
    logic [1:0]  output_sel;
    logic [7:0]  out_data;
    logic        done = 1'b0;
    int          n_pass = 0;
    int          n_tot = 0;
    logic [31:0] busy_na, busy_nb;

    always #5 clk = ~clk;

    tpu_host_sequencer #(.TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .A_flat(A_flat), .B_flat(B_flat), .res_valid(res_valid), .res_ready(res_ready),
        .C_flat(C_flat), .err(err), .ctrl_rst(ctrl_rst), .load_en(load_en),
        .load_sel_ab(load_sel_ab), .load_index(load_index), .in_data(in_data),
        .output_en(output_en), .output_sel(output_sel), .out_data(out_data), .done(done)
    );

    // 2x2 int8 matrix product, element k = row*2+col, results wrap to 8 bits
    function automatic logic [31:0] mm(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        int s;
        c = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += $signed(a[8*(2*i+k) +: 8]) * $signed(b[8*(2*k+j) +: 8]);
                c[8*(2*i+j) +: 8] = s[7:0];
            end
        return c;
    endfunction

    // controller model: stores writes, raises done a programmable delay after the 8th write
    logic [7:0]  mem [8];
    logic [31:0] ctl_c;
    int          wc = 0;
    int          cd = -1;
    int          ctl_dly = 0;
    bit          ctl_pulse = 0;
    bit          ctl_tie = 0;
    assign ctl_c = mm({mem[3], mem[2], mem[1], mem[0]}, {mem[7], mem[6], mem[5], mem[4]});
    assign out_data = 8'(ctl_c >> {output_sel, 3'b000});
    always @(posedge clk) begin
        if (ctrl_rst) begin
            wc <= 0;
            cd <= -1;
            done <= 1'b0;
        end else begin
            if (ctl_pulse && done) done <= 1'b0;
            if (load_en) begin
                mem[{load_sel_ab, load_index}] <= in_data;
                wc <= wc + 1;
            end
            if (load_en && wc == 7) begin
                if (ctl_dly == 0) done <= !ctl_tie;
                else cd <= ctl_dly - 1;
            end else if (cd == 0) begin
                done <= !ctl_tie;
                cd <= -1;
            end else if (cd > 0) cd <= cd - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // one full job: offer, watch every cycle until res_valid, optionally stall, then hand-shake
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int dly, input bit pulse,
                           input bit tie, input int hold, input bit busy, input logic [31:0] exp_c,
                           input bit exp_err, input string tag);
        int cyc, nload, nrst, rst_cyc, nout, exp_lat;
        bit seq_ok, excl_ok, jr_ok, st_ok;
        logic [31:0] c0;
        logic e0;
        logic [63:0] ab;
        ctl_dly = dly;
        ctl_pulse = pulse;
        ctl_tie = tie;
        ab = {b, a};
        exp_lat = tie ? 1 + 8 + TO + 1 : 1 + 8 + (dly + 1) + SC + 4 + 1;
        chk({tag, "_job_ready"}, 32'(job_ready), 32'd1);
        job_valid = 1'b1;
        A_flat = a;
        B_flat = b;
        res_ready = hold == 0;
        @(negedge clk);
        if (!busy) job_valid = 1'b0;
        cyc = 1; nload = 0; nrst = 0; rst_cyc = -1; nout = 0;
        seq_ok = 1; excl_ok = 1; jr_ok = 1;
        while (!res_valid && cyc < 300) begin
            if (busy) begin
                A_flat = $urandom;
                B_flat = $urandom;
            end
            if (job_ready) jr_ok = 0;
            if (int'(ctrl_rst) + int'(load_en) + int'(output_en) > 1) excl_ok = 0;
            if (ctrl_rst) begin
                nrst++;
                rst_cyc = cyc;
            end
            if (load_en) begin
                if (nload > 7 || cyc != 2 + nload || load_sel_ab != nload[2] ||
                    load_index != nload[1:0] || in_data != ab[8*nload +: 8]) seq_ok = 0;
                nload++;
            end
            if (output_en) nout++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_res_valid_seen"}, 32'(res_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_ctrl_rst_pulses"}, 32'(nrst), 32'd1);
        chk({tag, "_ctrl_rst_cycle"}, 32'(rst_cyc), 32'd1);
        chk({tag, "_load_beats"}, 32'(nload), 32'd8);
        chk({tag, "_load_order"}, 32'(seq_ok), 32'd1);
        chk({tag, "_read_beats"}, 32'(nout), exp_err ? 32'd0 : 32'd4);
        chk({tag, "_strobe_exclusive"}, 32'(excl_ok), 32'd1);
        chk({tag, "_busy_not_ready"}, 32'(jr_ok), 32'd1);
        chk({tag, "_C_flat"}, C_flat, exp_c);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        c0 = C_flat;
        e0 = err;
        st_ok = 1;
        for (int h = 0; h < hold; h++) begin
            if (busy) begin
                A_flat = $urandom;
                B_flat = $urandom;
            end
            @(negedge clk);
            if (!res_valid || C_flat !== c0 || err !== e0 || job_ready) st_ok = 0;
        end
        if (hold > 0) chk({tag, "_held_stable"}, 32'(st_ok), 32'd1);
        res_ready = 1'b1;
        if (busy) begin
            A_flat = busy_na;
            B_flat = busy_nb;
        end
        @(negedge clk);
        chk({tag, "_after_handshake"}, {29'd0, res_valid, err, job_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a, b;
        int dly;
        bit pulse, tie;
        int hold;
        logic [31:0] exp_c;
        bit exp_err;
    } vec_t;
    vec_t tbl [5];

    initial begin
        logic [31:0] ra, rb;
        tbl[0] = '{32'h04030201, 32'h08070605, 2, 0, 0, 0, 32'h322B1613, 0};
        tbl[1] = '{32'h01000001, 32'h06070809, 0, 1, 0, 0, 32'h06070809, 0};
        tbl[2] = '{32'h04030201, 32'h08070605, 0, 0, 1, 2, 32'h00000000, 1};
        tbl[3] = '{32'hFF0000FF, 32'h04030201, 5, 0, 0, 10, 32'hFCFDFEFF, 0};
        tbl[4] = '{32'h64646464, 32'h02020202, 1, 1, 0, 0, 32'h90909090, 0};
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({job_ready, ctrl_rst, load_en, load_sel_ab, load_index, in_data,
                                  output_en, output_sel, res_valid, err}), 32'h40000);
        chk("reset_C_flat", C_flat, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            run_job(tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].pulse, tbl[i].tie, tbl[i].hold, 1'b0,
                    tbl[i].exp_c, tbl[i].exp_err, $sformatf("vec%0d", i));
        busy_na = $urandom;
        busy_nb = $urandom;
        ra = $urandom;
        rb = $urandom;
        run_job(ra, rb, 8, 0, 0, 2, 1'b1, mm(ra, rb), 1'b0, "busy");
        run_job(busy_na, busy_nb, 3, 0, 0, 0, 1'b0, mm(busy_na, busy_nb), 1'b0, "after_busy");
        ra = 32'h11223344;
        rb = 32'h55667788;
        job_valid = 1'b1;
        A_flat = ra;
        B_flat = rb;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_at_beat3", 32'({load_en, load_index}), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("rst_strobes_drop", 32'({ctrl_rst, load_en, load_sel_ab, load_index, in_data, output_en,
                                     output_sel, res_valid, err}), 32'd0);
        chk("rst_job_ready", 32'(job_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(ra, rb, 4, 0, 0, 1, 1'b0, mm(ra, rb), 1'b0, "post_rst");
        for (int r = 0; r < 8; r++) begin
            ra = $urandom;
            rb = $urandom;
            run_job(ra, rb, int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), 1'b0,
                    int'($urandom_range(0, 3)), 1'b0, mm(ra, rb), 1'b0, $sformatf("rnd%0d", r));
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
